sobol_rng_param: RTL and testbench
==================================

Name: sobol_rng_param

Overview:
Parametrised Sobol low-discrepancy RNG, successor to the fixed 8-bit Sobol generator. Uses the Gray-code construction: each enabled cycle XORs one direction vector, selected by the least-significant-zero index of an internal counter, into the state. Direction vectors are run-time loadable, so one instance can produce any Sobol dimension. Drives unary bitstream generators: a comparator against the source value consumes sobol_out.

Parameters:
WIDTH, 8, bit width of counter, state and direction vectors (2..16)
LOGW, $clog2(WIDTH+1), width of the LSZ index; must be able to encode WIDTH

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  advance one sequence step this cycle
clr  input  1  synchronous restart of the sequence; direction vectors are kept
dir_wr  input  1  write strobe for a direction vector
dir_idx  input  LOGW  direction vector index, 0..WIDTH-1
dir_data  input  WIDTH  direction vector value
sobol_out  output  WIDTH  registered Sobol sample
cnt_out  output  WIDTH  registered step counter n
wrap  output  1  one-cycle pulse when the period completes

Behaviour:
- Reset (rst_n=0, asynchronous): sobol_out=0, cnt_out=0, wrap=0.
- Reset also loads the direction vector array with the dimension-1 (van der Corput) set: v[k] = 1 << (WIDTH-1-k).
- Step rule, on a rising edge with enable=1 and clr=0:
  - c = LSZ(cnt), the index of the lowest 0 bit of cnt.
  - sobol_out <= sobol_out ^ v[c].
  - cnt <= cnt+1.
- LSZ is combinational: it returns the lowest zero index, or WIDTH when cnt is all ones.
- Wrap (cnt all ones while enabled):
  - cnt <= 0, sobol_out <= 0, wrap <= 1 for exactly one cycle.
  - The period is therefore 2^WIDTH samples, starting with 0.
- enable=0: all state holds; wrap <= 0.
- Latency: the sample for step n+1 appears one clock after the enabling edge. There are no bubbles; enable may be held high continuously.
- clr=1: cnt <= 0, sobol_out <= 0, wrap <= 0. clr has priority over enable.
- Direction vector writes:
  - dir_wr=1 writes v[dir_idx] <= dir_data at the edge.
  - A step in the same cycle uses the old v[c]; the new value is first used on the next step.
  - Writes with dir_idx >= WIDTH are ignored.
  - Writes are accepted regardless of enable and clr.
- Reset mid-sequence returns everything to the post-reset state, including the default vectors.
- sobol_out and cnt_out are direct register outputs; there is no combinational path from inputs to outputs.

Optional Feature:
Macro SOBOL_SCRAMBLE_EN.
- When defined:
  - Adds input scr_wr (1) and input scr_data (WIDTH), plus an internal scramble mask register (reset 0).
  - scr_wr=1 loads the mask.
  - sobol_out presents state ^ mask, still registered: the mask is applied when loading the output register. The internal unscrambled state is kept separately.
  - A mask change becomes visible on the next enabled step or clr.
- When undefined: no extra ports; sobol_out is the raw state.

Decomposition:
- Package sobol_pkg holds:
  - the localparam function computing LOGW;
  - the default direction vector function dir_default(k, WIDTH);
  - a typedef for the direction vector array.
- Sub-module sobol_lsz (parameter WIDTH): purely combinational lowest-zero index encoder with output width LOGW. It is instantiated once; the top holds all state.

Test Plan:
- Reset, then enable held for 8 cycles, WIDTH=8 -> sobol_out = 0x80, 0xC0, 0x40, 0x60, 0xE0, 0xA0, 0x20, 0x30; cnt_out = 1..8.
- Enable for 256 cycles, WIDTH=8 -> all 256 values appear exactly once (0 at the start). wrap pulses once on the cycle cnt goes 0xFF->0x00; then sobol_out=0.
- At cnt=5 assert clr with enable=1 -> next cycle cnt_out=0, sobol_out=0, no wrap. Vectors are retained: a subsequent step gives 0x80.
- Write v[0]=0x01 in the same cycle as an enabled step from cnt=0 -> that step gives 0x80 (old vector). After clr, the first step gives 0x01.
- Drop rst_n asynchronously mid-cycle at cnt=37 -> outputs are 0 immediately, before the next edge, and v[0] reads back the default 0x80. A write with dir_idx=8 (WIDTH=8) is ignored.
- With SOBOL_SCRAMBLE_EN, load mask 0xFF then step twice -> sobol_out = 0x7F, 0x3F.

Source files
------------

// File: rtl/sobol_pkg.sv
// sobol_pkg: shared sizing helpers, default direction vectors and vector types for the Sobol RNG.
package sobol_pkg;

    localparam int MAX_WIDTH = 16;

    typedef logic [MAX_WIDTH-1:0] dir_word_t;
    typedef dir_word_t dir_arr_t [MAX_WIDTH];

    function automatic int sobol_logw(input int w);
        return $clog2(w + 1);
    endfunction

    // Dimension-1 (van der Corput) set: v[k] has only bit WIDTH-1-k set
    function automatic dir_word_t dir_default(input int k, input int w);
        return dir_word_t'(1) << (w - 1 - k);
    endfunction

endpackage

// File: rtl/sobol_lsz.sv
// sobol_lsz: combinational index of the lowest zero bit of cnt; returns WIDTH when cnt is all ones.
module sobol_lsz
    import sobol_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LOGW  = sobol_logw(WIDTH)
) (
    input  logic [WIDTH-1:0] cnt,
    output logic [LOGW-1:0]  idx
);

    always_comb begin
        idx = LOGW'(WIDTH);
        for (int i = WIDTH - 1; i >= 0; i--)
            if (!cnt[i]) idx = LOGW'(i);
    end

endmodule

// File: rtl/sobol_rng_param.sv
// sobol_rng_param: Gray-code Sobol generator with run-time loadable direction vectors.
// Define SOBOL_SCRAMBLE_EN to add an XOR scramble mask applied on the output register.
module sobol_rng_param
    import sobol_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LOGW  = sobol_logw(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clr,
    input  logic             dir_wr,
    input  logic [LOGW-1:0]  dir_idx,
    input  logic [WIDTH-1:0] dir_data,
`ifdef SOBOL_SCRAMBLE_EN
    input  logic             scr_wr,
    input  logic [WIDTH-1:0] scr_data,
`endif
    output logic [WIDTH-1:0] sobol_out,
    output logic [WIDTH-1:0] cnt_out,
    output logic             wrap
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] v_q [WIDTH];
    logic [WIDTH-1:0] v_d [WIDTH];
    logic [WIDTH-1:0] v_sel;
    logic [LOGW-1:0]  c;
    logic             all_ones;

    sobol_lsz #(.WIDTH(WIDTH), .LOGW(LOGW)) u_lsz (
        .cnt (cnt_q),
        .idx (c)
    );

    assign all_ones = &cnt_q;

    // Selection by compare keeps c == WIDTH (all ones) from reading past the array
    always_comb begin
        v_sel = '0;
        for (int k = 0; k < WIDTH; k++)
            if (c == LOGW'(k)) v_sel = v_q[k];
    end

    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        wrap_d  = 1'b0;
        if (clr) begin
            cnt_d   = '0;
            state_d = '0;
        end else if (enable) begin
            cnt_d   = cnt_q + WIDTH'(1);
            state_d = all_ones ? '0 : state_q ^ v_sel;
            wrap_d  = all_ones;
        end
        for (int k = 0; k < WIDTH; k++)
            v_d[k] = (dir_wr && dir_idx == LOGW'(k)) ? dir_data : v_q[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            state_q <= '0;
            wrap_q  <= 1'b0;
            for (int k = 0; k < WIDTH; k++)
                v_q[k] <= WIDTH'(dir_default(k, WIDTH));
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            wrap_q  <= wrap_d;
            v_q     <= v_d;
        end
    end

`ifdef SOBOL_SCRAMBLE_EN
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] out_q, out_d;

    // The mask in force before this edge is applied; a freshly loaded mask waits for the next step
    always_comb begin
        mask_d = scr_wr ? scr_data : mask_q;
        out_d  = (clr || enable) ? state_d ^ mask_q : out_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
            out_q  <= '0;
        end else begin
            mask_q <= mask_d;
            out_q  <= out_d;
        end
    end

    assign sobol_out = out_q;
`else
    assign sobol_out = state_q;
`endif

    assign cnt_out = cnt_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_sobol_rng_param.sv
// tb_sobol_rng_param: directed self-checking bench for sobol_rng_param at WIDTH=8.
module tb_sobol_rng_param;

    localparam int WIDTH = 8;
    localparam int LOGW  = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic             clr = 1'b0;
    logic             dir_wr = 1'b0;
    logic [LOGW-1:0]  dir_idx = '0;
    logic [WIDTH-1:0] dir_data = '0;
`ifdef SOBOL_SCRAMBLE_EN
    logic             scr_wr = 1'b0;
    logic [WIDTH-1:0] scr_data = '0;
`endif
    logic [WIDTH-1:0] sobol_out;
    logic [WIDTH-1:0] cnt_out;
    logic             wrap;

    int checks = 0;
    int failures = 0;

    sobol_rng_param #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .clr       (clr),
        .dir_wr    (dir_wr),
        .dir_idx   (dir_idx),
        .dir_data  (dir_data),
`ifdef SOBOL_SCRAMBLE_EN
        .scr_wr    (scr_wr),
        .scr_data  (scr_data),
`endif
        .sobol_out (sobol_out),
        .cnt_out   (cnt_out),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        enable = 1'b0; clr = 1'b0; dir_wr = 1'b0;
`ifdef SOBOL_SCRAMBLE_EN
        scr_wr = 1'b0;
`endif
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (sobol_out !== 8'h00 || cnt_out !== 8'h00 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL reset: sobol=%h cnt=%h wrap=%b, required 00 00 0", sobol_out, cnt_out, wrap);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_sequence();
        logic [WIDTH-1:0] exp [8] = '{8'h80, 8'hC0, 8'h40, 8'h60, 8'hE0, 8'hA0, 8'h20, 8'h30};
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (sobol_out !== exp[i] || cnt_out !== WIDTH'(i + 1)) begin
                failures++;
                $display("FAIL seq step %0d: sobol=%h cnt=%h, required %h %h", i + 1, sobol_out, cnt_out, exp[i], i + 1);
            end
        end
        enable = 1'b0;
        tick();
        tick();
        checks++;
        if (sobol_out !== 8'h30 || cnt_out !== 8'd8 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL hold: sobol=%h cnt=%h wrap=%b, required 30 08 0", sobol_out, cnt_out, wrap);
        end
    endtask

    task automatic test_period();
        bit seen [256];
        int uniq = 0;
        int wraps = 0;
        do_reset();
        foreach (seen[i]) seen[i] = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 256; i++) begin
            if (!seen[sobol_out]) uniq++;
            seen[sobol_out] = 1'b1;
            if (i == 0) begin
                checks++;
                if (sobol_out !== 8'h00) begin
                    failures++;
                    $display("FAIL period start: sobol=%h, required 00", sobol_out);
                end
            end
            tick();
            if (wrap) wraps++;
            if (wrap && i != 255) begin
                checks++;
                failures++;
                $display("FAIL early wrap at step %0d: cnt=%h, required no wrap", i + 1, cnt_out);
            end
        end
        checks++;
        if (uniq !== 256) begin
            failures++;
            $display("FAIL period unique: got %0d distinct values, required 256", uniq);
        end
        checks++;
        if (wraps !== 1 || wrap !== 1'b1 || sobol_out !== 8'h00 || cnt_out !== 8'h00) begin
            failures++;
            $display("FAIL wrap: pulses=%0d wrap=%b sobol=%h cnt=%h, required 1 1 00 00", wraps, wrap, sobol_out, cnt_out);
        end
        tick();
        checks++;
        if (wrap !== 1'b0 || sobol_out !== 8'h80 || cnt_out !== 8'h01) begin
            failures++;
            $display("FAIL post wrap: wrap=%b sobol=%h cnt=%h, required 0 80 01", wrap, sobol_out, cnt_out);
        end
        enable = 1'b0;
    endtask

    task automatic test_clr();
        do_reset();
        enable = 1'b1;
        repeat (5) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (sobol_out !== 8'h00 || cnt_out !== 8'h00 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL clr: sobol=%h cnt=%h wrap=%b, required 00 00 0", sobol_out, cnt_out, wrap);
        end
        tick();
        checks++;
        if (sobol_out !== 8'h80 || cnt_out !== 8'h01) begin
            failures++;
            $display("FAIL clr then step: sobol=%h cnt=%h, required 80 01", sobol_out, cnt_out);
        end
        enable = 1'b0;
    endtask

    task automatic test_dir_write();
        do_reset();
        enable = 1'b1;
        dir_wr = 1'b1; dir_idx = 4'd0; dir_data = 8'h01;
        tick();
        dir_wr = 1'b0;
        checks++;
        if (sobol_out !== 8'h80) begin
            failures++;
            $display("FAIL dir write same cycle: sobol=%h, required 80", sobol_out);
        end
        enable = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0; enable = 1'b1;
        tick();
        enable = 1'b0;
        checks++;
        if (sobol_out !== 8'h01) begin
            failures++;
            $display("FAIL dir write used: sobol=%h, required 01", sobol_out);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        enable = 1'b1;
        repeat (37) tick();
        enable = 1'b0;
        checks++;
        if (cnt_out !== 8'd37 || sobol_out !== 8'hEC) begin
            failures++;
            $display("FAIL step 37: sobol=%h cnt=%h, required EC 25", sobol_out, cnt_out);
        end
        dir_wr = 1'b1; dir_idx = 4'd0; dir_data = 8'h01;
        tick();
        dir_wr = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (sobol_out !== 8'h00 || cnt_out !== 8'h00 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL async reset: sobol=%h cnt=%h wrap=%b, required 00 00 0", sobol_out, cnt_out, wrap);
        end
        #1;
        rst_n = 1'b1;
        tick();
        dir_wr = 1'b1; dir_idx = 4'd8; dir_data = 8'h01;
        tick();
        dir_wr = 1'b0; enable = 1'b1;
        tick();
        checks++;
        if (sobol_out !== 8'h80) begin
            failures++;
            $display("FAIL default vector / ignored write: sobol=%h, required 80", sobol_out);
        end
        tick();
        enable = 1'b0;
        checks++;
        if (sobol_out !== 8'hC0) begin
            failures++;
            $display("FAIL second step after reset: sobol=%h, required C0", sobol_out);
        end
    endtask

`ifdef SOBOL_SCRAMBLE_EN
    task automatic test_scramble();
        do_reset();
        scr_wr = 1'b1; scr_data = 8'hFF;
        tick();
        scr_wr = 1'b0;
        checks++;
        if (sobol_out !== 8'h00) begin
            failures++;
            $display("FAIL mask before step: sobol=%h, required 00", sobol_out);
        end
        enable = 1'b1;
        tick();
        checks++;
        if (sobol_out !== 8'h7F) begin
            failures++;
            $display("FAIL scramble step 1: sobol=%h, required 7F", sobol_out);
        end
        tick();
        enable = 1'b0;
        checks++;
        if (sobol_out !== 8'h3F) begin
            failures++;
            $display("FAIL scramble step 2: sobol=%h, required 3F", sobol_out);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sequence();
        test_period();
        test_clr();
        test_dir_write();
        test_async_reset();
`ifdef SOBOL_SCRAMBLE_EN
        test_scramble();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
